// File: rtl/c17_pkg.sv
// c17_pkg: shared definitions for the ISCAS c17 netlist with stuck-at fault
// injection. It holds the fault-site encoding, the registered fault
// configuration struct and a small override helper.
package c17_pkg;

    localparam int SITE_W    = 5;   // width of the fault site select
    localparam int NUM_SITES = 17;  // sites 0..16 are valid; 17..31 mean no fault

    // Stem sites: a fault forces the net and every branch it feeds
    localparam logic [SITE_W-1:0] SITE_N1  = 5'd0;
    localparam logic [SITE_W-1:0] SITE_N2  = 5'd1;
    localparam logic [SITE_W-1:0] SITE_N3  = 5'd2;
    localparam logic [SITE_W-1:0] SITE_N6  = 5'd3;
    localparam logic [SITE_W-1:0] SITE_N7  = 5'd4;
    localparam logic [SITE_W-1:0] SITE_N10 = 5'd5;
    localparam logic [SITE_W-1:0] SITE_N11 = 5'd6;
    localparam logic [SITE_W-1:0] SITE_N16 = 5'd7;
    localparam logic [SITE_W-1:0] SITE_N19 = 5'd8;
    localparam logic [SITE_W-1:0] SITE_N22 = 5'd9;
    localparam logic [SITE_W-1:0] SITE_N23 = 5'd10;
    // Branch sites: a fault forces only the one gate input
    localparam logic [SITE_W-1:0] SITE_N3_N10  = 5'd11;
    localparam logic [SITE_W-1:0] SITE_N3_N11  = 5'd12;
    localparam logic [SITE_W-1:0] SITE_N11_N16 = 5'd13;
    localparam logic [SITE_W-1:0] SITE_N11_N19 = 5'd14;
    localparam logic [SITE_W-1:0] SITE_N16_N22 = 5'd15;
    localparam logic [SITE_W-1:0] SITE_N16_N23 = 5'd16;

    typedef struct packed {
        logic              en;
        logic [SITE_W-1:0] site;
        logic              val;
    } fault_cfg_t;

    // Replace a net value with the stuck-at value when its site is selected
    function automatic logic ovr(input logic x, input logic hit, input logic v);
        return hit ? v : x;
    endfunction

endpackage

// File: rtl/c17_fault_net.sv
// c17_fault_net: the c17 NAND network with a stuck-at override mux on every
// stem and fanout branch. Purely combinational.
// Ports:
//   n1,n2,n3,n6,n7 : primary inputs
//   cfg            : registered fault configuration
//   n22,n23        : (possibly faulted) primary outputs
module c17_fault_net
    import c17_pkg::*;
#(
    parameter bit FAULT_INJ = 1'b1
) (
    input  logic       n1,
    input  logic       n2,
    input  logic       n3,
    input  logic       n6,
    input  logic       n7,
    input  fault_cfg_t cfg,
    output logic       n22,
    output logic       n23
);

    logic                 active;
    logic [NUM_SITES-1:0] hit;     // one-hot selected site, zero when inactive

    logic f1, f2, f3, f6, f7;
    logic f3_10, f3_11;
    logic f10, f11, f11_16, f11_19;
    logic f16, f19, f16_22, f16_23;

    // Out-of-range sites fall through as "no fault", so the shift stays in range
    assign active = FAULT_INJ && cfg.en && (cfg.site < SITE_W'(NUM_SITES));
    assign hit    = active ? (NUM_SITES'(1) << cfg.site) : '0;

    // Stems
    assign f1 = ovr(n1, hit[SITE_N1], cfg.val);
    assign f2 = ovr(n2, hit[SITE_N2], cfg.val);
    assign f3 = ovr(n3, hit[SITE_N3], cfg.val);
    assign f6 = ovr(n6, hit[SITE_N6], cfg.val);
    assign f7 = ovr(n7, hit[SITE_N7], cfg.val);

    // N3 fans out; each branch can be forced on its own after the stem mux
    assign f3_10 = ovr(f3, hit[SITE_N3_N10], cfg.val);
    assign f3_11 = ovr(f3, hit[SITE_N3_N11], cfg.val);

    assign f10 = ovr(~(f1 & f3_10), hit[SITE_N10], cfg.val);
    assign f11 = ovr(~(f3_11 & f6), hit[SITE_N11], cfg.val);

    assign f11_16 = ovr(f11, hit[SITE_N11_N16], cfg.val);
    assign f11_19 = ovr(f11, hit[SITE_N11_N19], cfg.val);

    assign f16 = ovr(~(f2 & f11_16), hit[SITE_N16], cfg.val);
    assign f19 = ovr(~(f11_19 & f7), hit[SITE_N19], cfg.val);

    assign f16_22 = ovr(f16, hit[SITE_N16_N22], cfg.val);
    assign f16_23 = ovr(f16, hit[SITE_N16_N23], cfg.val);

    assign n22 = ovr(~(f10 & f16_22), hit[SITE_N22], cfg.val);
    assign n23 = ovr(~(f16_23 & f19), hit[SITE_N23], cfg.val);

endmodule

// File: rtl/c17.sv
// c17: ISCAS c17 benchmark with a single-site stuck-at fault injector.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   N1,N2,N3,N6,N7              : primary inputs
//   N22,N23                     : combinational outputs (zero latency)
//   N22_q,N23_q                 : outputs registered one cycle later
//   fault_load                  : capture fault_en/fault_site/fault_val
//   fault_site,fault_en,fault_val : fault configuration
module c17
    import c17_pkg::*;
#(
    parameter bit FAULT_INJ = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              N1,
    input  logic              N2,
    input  logic              N3,
    input  logic              N6,
    input  logic              N7,
    input  logic              fault_load,
    input  logic [SITE_W-1:0] fault_site,
    input  logic              fault_en,
    input  logic              fault_val,
    output logic              N22,
    output logic              N23,
    output logic              N22_q,
    output logic              N23_q
);

    fault_cfg_t cfg;

    generate
        if (FAULT_INJ) begin : g_fault
            // Async clear drops any active fault the moment reset asserts
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cfg <= '0;
                else if (fault_load)
                    cfg <= '{en: fault_en, site: fault_site, val: fault_val};
            end
        end else begin : g_no_fault
            assign cfg = '0;
        end
    endgenerate

    c17_fault_net #(.FAULT_INJ(FAULT_INJ)) u_net (
        .n1  (N1),
        .n2  (N2),
        .n3  (N3),
        .n6  (N6),
        .n7  (N7),
        .cfg (cfg),
        .n22 (N22),
        .n23 (N23)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            N22_q <= 1'b0;
            N23_q <= 1'b0;
        end else begin
            N22_q <= N22;
            N23_q <= N23;
        end
    end

endmodule

// File: tb/tb_c17.sv
// tb_c17: randomized self-checking bench for c17 against a behavioural model
// of the netlist with a single stuck-at site.
module tb_c17;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       N1, N2, N3, N6, N7;
    logic       fault_load;
    logic [4:0] fault_site;
    logic       fault_en;
    logic       fault_val;
    logic       N22, N23, N22_q, N23_q;

    int n_run  = 0;
    int n_fail = 0;

    // model copy of the fault configuration the DUT should hold
    logic       m_en;
    logic [4:0] m_site;
    logic       m_val;

    always #5 clk = ~clk;

    c17 #(.FAULT_INJ(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .N1         (N1),
        .N2         (N2),
        .N3         (N3),
        .N6         (N6),
        .N7         (N7),
        .fault_load (fault_load),
        .fault_site (fault_site),
        .fault_en   (fault_en),
        .fault_val  (fault_val),
        .N22        (N22),
        .N23        (N23),
        .N22_q      (N22_q),
        .N23_q      (N23_q)
    );

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Behavioural model: net values kept in an array indexed by fault site;
    // the selected site is replaced by the stuck value as the net is formed.
    function automatic logic [1:0] model(input logic [4:0] in, input logic en,
                                         input logic [4:0] site, input logic val);
        logic w [0:16];
        int   s;
        s = (en && site <= 5'd16) ? int'(site) : -1;
        w[0] = in[4]; w[1] = in[3]; w[2] = in[2]; w[3] = in[1]; w[4] = in[0];
        for (int k = 0; k <= 4; k++) if (k == s) w[k] = val;
        w[11] = (s == 11) ? val : w[2];
        w[12] = (s == 12) ? val : w[2];
        w[5]  = (s == 5)  ? val : !(w[0] && w[11]);
        w[6]  = (s == 6)  ? val : !(w[12] && w[3]);
        w[13] = (s == 13) ? val : w[6];
        w[14] = (s == 14) ? val : w[6];
        w[7]  = (s == 7)  ? val : !(w[1] && w[13]);
        w[8]  = (s == 8)  ? val : !(w[14] && w[4]);
        w[15] = (s == 15) ? val : w[7];
        w[16] = (s == 16) ? val : w[7];
        w[9]  = (s == 9)  ? val : !(w[5] && w[15]);
        w[10] = (s == 10) ? val : !(w[16] && w[8]);
        return {w[9], w[10]};
    endfunction

    function automatic logic [4:0] cur_in();
        return {N1, N2, N3, N6, N7};
    endfunction

    task automatic set_in(input logic [4:0] v);
        {N1, N2, N3, N6, N7} = v;
    endtask

    // Advance one clock; registered outputs must show what N22/N23 were just
    // before the edge, and a pending fault_load updates the model config.
    task automatic tick(input string tag);
        logic [1:0] exp_q;
        exp_q = model(cur_in(), m_en, m_site, m_val);
        @(posedge clk);
        if (fault_load) begin
            m_en = fault_en; m_site = fault_site; m_val = fault_val;
        end
        #1;
        fault_load = 1'b0;
        chk(tag, {N22_q, N23_q}, exp_q);
    endtask

    task automatic check_comb(input string tag);
        #1;
        chk(tag, {N22, N23}, model(cur_in(), m_en, m_site, m_val));
    endtask

    task automatic load(input logic en, input logic [4:0] site, input logic val);
        fault_load = 1'b1; fault_en = en; fault_site = site; fault_val = val;
        tick("load_q");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; fault_load = 1'b0; fault_site = '0; fault_en = 1'b0; fault_val = 1'b0;
        set_in(5'b00000);
        m_en = 1'b0; m_site = '0; m_val = 1'b0;
        #12;
        chk("reset_q", {N22_q, N23_q}, 2'b00);
        chk("reset_comb_00000", {N22, N23}, 2'b00);
        @(negedge clk); rst_n = 1'b1;
        tick("first_q_00000");
        chk("first_q_const", {N22_q, N23_q}, 2'b00);

        // directed patterns with fixed expectations
        set_in(5'b11111); #1; chk("comb_11111", {N22, N23}, 2'b10);
        set_in(5'b10101); #1; chk("comb_10101", {N22, N23}, 2'b11);
        tick("q_10101");
        chk("q_10101_const", {N22_q, N23_q}, 2'b11);

        set_in(5'b11111);
        load(1'b1, 5'd7, 1'b0);
        #1; chk("n16_stem_sa0", {N22, N23}, 2'b11);
        load(1'b1, 5'd15, 1'b0);
        #1; chk("n16_n22_branch_sa0", {N22, N23}, 2'b10);

        // reset mid-cycle clears an active fault at once
        load(1'b1, 5'd16, 1'b0);
        #1; chk("n16_n23_branch_sa0", {N22, N23}, 2'b11);
        tick("q_site16");
        #2; rst_n = 1'b0; m_en = 1'b0; m_site = '0; m_val = 1'b0;
        #1;
        chk("reset_comb_clear", {N22, N23}, 2'b10);
        chk("reset_q_async", {N22_q, N23_q}, 2'b00);
        @(negedge clk); rst_n = 1'b1;
        tick("post_reset_q");

        // out-of-range site with enable set behaves as no fault
        load(1'b1, 5'd20, 1'b1);
        for (int p = 0; p < 32; p++) begin
            set_in(5'(p));
            #1; chk("site20_nofault", {N22, N23}, model(5'(p), 1'b0, 5'd0, 1'b0));
        end

        // exhaustive no-fault sweep with registered follow-up
        load(1'b0, 5'd0, 1'b0);
        for (int p = 0; p < 32; p++) begin
            set_in(5'(p));
            check_comb("sweep_comb");
            tick("sweep_q");
        end

        // every site, both polarities, all patterns
        for (int s = 0; s < 17; s++) begin
            for (int v = 0; v < 2; v++) begin
                load(1'b1, 5'(s), v[0]);
                for (int p = 0; p < 32; p++) begin
                    set_in(5'(p));
                    check_comb("site_sweep");
                end
            end
        end

        // random mix: inputs and loads may change together
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) begin
                fault_load = 1'b1;
                fault_en   = 1'($urandom_range(0, 1));
                fault_site = 5'($urandom_range(0, 31));
                fault_val  = 1'($urandom_range(0, 1));
            end
            check_comb("rand_comb");
            tick("rand_q");
            check_comb("rand_comb_post");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
